// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: round-robin arbiter for the coprocessor's single shared memory port
//   i_Clock        system clock, rising edge
//   i_Reset        asynchronous active-high reset
//   i_Request      per-requester level request (0 = main CU, 1.. = processing units)
//   o_Grant        registered one-hot grant
//   o_Grant_Valid  OR of o_Grant
//   o_Grant_Index  index of the current owner, meaningful while o_Grant_Valid
//   o_Timeout      one-cycle pulse when the hold limit forces a release
module memory_bus_arbiter #(
    parameter int N_REQ    = 5,
    parameter int MAX_HOLD = 64
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic [N_REQ-1:0]         i_Request,
    output logic [N_REQ-1:0]         o_Grant,
    output logic                     o_Grant_Valid,
    output logic [$clog2(N_REQ)-1:0] o_Grant_Index,
    output logic                     o_Timeout
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]    index_q, index_d, last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic [N_REQ-1:0] rot;
    logic [IW-1:0]    off, winner;
    logic [IW+1:0]    sum;
    logic             owner_req, hold_expired;
    // Rotate requests so bit 0 is the requester just after the last owner; the
    // lowest set bit of the rotated vector is then the round-robin winner.
    always_comb begin
        rot = N_REQ'({i_Request, i_Request} >> ({1'b0, last_q} + (IW+1)'(1)));
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = IW'(k);
        end
        sum    = {2'b0, last_q} + (IW+2)'(1) + {2'b0, off};
        winner = (sum >= (IW+2)'(N_REQ)) ? IW'(sum - (IW+2)'(N_REQ)) : IW'(sum);
    end
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        index_d      = index_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        timeout_d    = 1'b0;
        owner_req    = |(grant_q & i_Request);
        hold_expired = (MAX_HOLD != 0) && (cnt_q == CW'(MAX_HOLD - 1));
        case (state_q)
            GRANT: begin
                cnt_d = (MAX_HOLD == 0 || &cnt_q) ? cnt_q : cnt_q + CW'(1);
                if (!owner_req || hold_expired) begin
                    grant_d   = '0;
                    state_d   = RELEASE;
                    // A voluntary drop on the expiry edge is a normal release.
                    timeout_d = owner_req;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
                if (|i_Request) begin
                    grant_d = N_REQ'(1) << winner;
                    index_d = winner;
                    last_d  = winner;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
        endcase
    end
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            index_q   <= '0;
            last_q    <= IW'(N_REQ - 1);
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            index_q   <= index_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign o_Grant       = grant_q;
    assign o_Grant_Valid = |grant_q;
    assign o_Grant_Index = index_q;
    assign o_Timeout     = timeout_q;
endmodule
